// File: rtl/rvc_fetch_pkg.sv
// rtl/rvc_fetch_pkg.sv - shared types and helpers for the RV32IC fetch front end
package rvc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  localparam logic [1:0] OPC_32BIT = 2'b11;

  // Cache delivers words big-endian; the core wants little-endian halfwords.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rvc_hw_queue.sv
// rtl/rvc_hw_queue.sv - circular halfword FIFO, push/pop 0..2 entries per cycle
module rvc_hw_queue
  import rvc_fetch_pkg::*;
#(
  parameter int HQ_DEPTH = 8,
  localparam int AW = $clog2(HQ_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic [1:0]    push_cnt_i,
  input  logic [15:0]   push_data0_i,
  input  logic [15:0]   push_data1_i,
  input  logic [1:0]    pop_cnt_i,
  output logic [15:0]   head0_o,
  output logic [15:0]   head1_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   free_o
);

  logic [15:0]   mem_q [HQ_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [AW:0]   count_q;

  assign rd_ptr_p1 = rd_ptr_q + AW'(1);
  assign wr_ptr_p1 = wr_ptr_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(pop_cnt_i);
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      count_q  <= count_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_cnt_i);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!clear_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_ptr_q]  <= push_data0_i;
      if (push_cnt_i == 2'd2) mem_q[wr_ptr_p1] <= push_data1_i;
    end
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_p1];
  assign count_o = count_q;
  assign free_o  = (AW+1)'(HQ_DEPTH) - count_q;

endmodule

// File: rtl/rvc_fetch_unit.sv
// rtl/rvc_fetch_unit.sv - RV32IC fetch front end: word fetch, halfword queue, RVC/32-bit assembly
module rvc_fetch_unit
  import rvc_fetch_pkg::*;
#(
  parameter int          HQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_ren,
  output logic [29:0] icache_addr,
  input  logic        icache_stall,
  input  logic [31:0] icache_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc,
  output logic        instr_is_rvc
);

  localparam int AW = $clog2(HQ_DEPTH);

  fetch_state_e state_q, state_d;
  logic [29:0]  fetch_addr_q, fetch_addr_d;
  logic [29:0]  kill_addr_q, kill_addr_d;
  logic [31:0]  head_pc_q, head_pc_d;
  logic         drop_low_q, drop_low_d;

  logic [15:0]  h0, h1, push0, push1;
  logic [AW:0]  count, free;
  logic [31:0]  word;
  logic [1:0]   push_cnt, pop_cnt;
  logic         fetch_done, is32, fire;

  rvc_hw_queue #(.HQ_DEPTH(HQ_DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (redirect_valid),
    .push_cnt_i   (push_cnt),
    .push_data0_i (push0),
    .push_data1_i (push1),
    .pop_cnt_i    (pop_cnt),
    .head0_o      (h0),
    .head1_o      (h1),
    .count_o      (count),
    .free_o       (free)
  );

  assign word        = bswap32(icache_rdata);
  assign icache_ren  = (state_q == ST_KILL) |
                       ((state_q == ST_RUN) & (free >= (AW+1)'(2)));
  assign icache_addr = (state_q == ST_KILL) ? kill_addr_q : fetch_addr_q;
  assign fetch_done  = icache_ren & ~icache_stall;

  assign is32         = (h0[1:0] == OPC_32BIT);
  assign instr_valid  = is32 ? (count >= (AW+1)'(2)) : (count != '0);
  assign instr_is_rvc = instr_valid & ~is32;
  assign instr_o      = !instr_valid ? 32'h0 : (is32 ? {h1, h0} : {16'h0, h0});
  assign instr_pc     = head_pc_q;
  assign fire         = instr_valid & instr_ready & ~redirect_valid;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    kill_addr_d  = kill_addr_q;
    head_pc_d    = head_pc_q;
    drop_low_d   = drop_low_q;
    push_cnt     = 2'd0;
    push0        = drop_low_q ? word[31:16] : word[15:0];
    push1        = word[31:16];
    pop_cnt      = 2'd0;

    if (fire) begin
      pop_cnt   = is32 ? 2'd2 : 2'd1;
      head_pc_d = head_pc_q + (is32 ? 32'd4 : 32'd2);
    end

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (fetch_done && !redirect_valid) begin
          push_cnt     = drop_low_q ? 2'd1 : 2'd2;
          fetch_addr_d = fetch_addr_q + 30'd1;
          drop_low_d   = 1'b0;
        end
      end
      ST_KILL: if (fetch_done) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    // A stalled request cannot be withdrawn; park its address and swallow its data in KILL.
    if (redirect_valid) begin
      fetch_addr_d = redirect_pc[31:2];
      drop_low_d   = redirect_pc[1];
      head_pc_d    = {redirect_pc[31:1], 1'b0};
      if (state_q == ST_RUN && icache_ren && icache_stall) begin
        state_d     = ST_KILL;
        kill_addr_d = fetch_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      fetch_addr_q <= RESET_PC[31:2];
      kill_addr_q  <= '0;
      head_pc_q    <= {RESET_PC[31:1], 1'b0};
      drop_low_q   <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      kill_addr_q  <= kill_addr_d;
      head_pc_q    <= head_pc_d;
      drop_low_q   <= drop_low_d;
    end
  end

endmodule

// File: doc/rvc_fetch_unit.md
Name: rvc_fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RV32IC core; sits between the instruction cache port and the IF/ID register.
- Fetches aligned 32-bit words and byte-swaps them to little-endian.
- Splits each word into halfwords in a prefetch queue and re-assembles 16-bit compressed and 32-bit (possibly word-straddling) instructions.
- Presents one instruction per cycle to decode with a valid/ready handshake.
- Supports pipeline redirect (branch/jump flush) at any halfword-aligned PC, including one with an outstanding cache miss.

Parameters:
- HQ_DEPTH, 8, halfword queue entries; power of 2, minimum 4.
- RESET_PC, 32'h0000_0000, first fetch PC after reset; bit 0 ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icache_ren  out  1  fetch request
- icache_addr  out  30  word address, PC[31:2]
- icache_stall  in  1  cache busy; request completes in a cycle with icache_ren=1 and icache_stall=0
- icache_rdata  in  32  fetched word, big-endian byte order
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new PC; bit 0 ignored
- instr_valid  out  1  instr_o/instr_pc valid
- instr_ready  in  1  decode accepts this cycle
- instr_o  out  32  instruction; a compressed instruction sits in [15:0] with [31:16]=0
- instr_pc  out  32  PC of instr_o
- instr_is_rvc  out  1  instr_o is a 16-bit instruction

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=BOOT, icache_ren=0, queue count=0, instr_valid=0, instr_o=0, instr_is_rvc=0.
  - fetch_addr=RESET_PC[31:2], head_pc=RESET_PC with bit 0 cleared, drop_low=RESET_PC[1].
- FSM states:
  - BOOT: exactly one cycle after reset release, then RUN.
  - RUN: icache_ren=1 iff free entries >= 2, evaluated at start of cycle. Free space never shrinks while a request is pending, so ren stays high through a stall.
  - KILL: icache_ren=1 with icache_addr held; completion data is discarded, then RUN.
- icache_addr: equals fetch_addr and stays stable while icache_ren=1 and icache_stall=1.
- Fetch completion in RUN (ren=1, stall=0), with word w = byte-swapped rdata:
  - Push w[15:0] then w[31:16]; if drop_low=1, push only w[31:16] and clear drop_low.
  - fetch_addr increments by 1 and wraps modulo 2^30.
  - Data pushed this cycle is visible to decode the next cycle (1-cycle fill latency).
- Instruction assembly from head entry h0 and next entry h1:
  - h0[1:0]!=2'b11: 16-bit; valid when count>=1; instr_o={16'h0,h0}; instr_is_rvc=1.
  - h0[1:0]==2'b11: 32-bit; valid only when count>=2; instr_o={h1,h0}. A straddling instruction waits for the next word.
- Outputs instr_valid, instr_o, instr_pc and instr_is_rvc are combinational from queue head and head_pc.
- Handshake: on instr_valid & instr_ready, pop 1 (RVC) or 2 entries and advance head_pc by 2 or 4. Pop and push may occur in the same cycle; count updates by push count minus pop count.
- Redirect (redirect_valid=1), which has priority over pop and push in that cycle:
  - Queue cleared; instr_valid=0 next cycle.
  - fetch_addr=redirect_pc[31:2], drop_low=redirect_pc[1], head_pc={redirect_pc[31:1],1'b0}.
  - If a request is pending and stalled (ren=1, stall=1), go to KILL. The held address still completes, then the new address issues.
  - If the request completes in the same cycle as the redirect, its data is discarded and the state stays RUN.
  - A second redirect during KILL updates the target and stays in KILL.
- Full queue: ren=0 and no request issues until at least 2 entries are free.
- Empty queue: instr_valid=0. instr_ready has no effect when instr_valid=0.
- Pointer wrap: read and write pointers are log2(HQ_DEPTH) bits and wrap naturally; count is log2(HQ_DEPTH)+1 bits.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight cache completion is ignored, because ren is 0 in BOOT.

Decomposition:
- Package rvc_fetch_pkg holds:
  - the state encoding (BOOT, RUN, KILL);
  - the constant OPC_32BIT=2'b11;
  - a byte-swap function shared with the data path.
- Sub-module rvc_hw_queue: circular halfword FIFO.
  - Push port: 0/1/2 entries. Pop port: 0/1/2 entries.
  - Synchronous clear; exposes head two entries, count and free.
  - Parametrised by HQ_DEPTH.

Test Plan:
- Reset release, RESET_PC=0, stall=0, ready=1; words 0x13000000 (addi nop, swapped) then two C.NOPs packed as 0x01000100 -> three instructions at PC 0, 4, 6; instr_is_rvc=0, 1, 1; instr_o=0x00000013, 0x00000001, 0x00000001.
- Straddle: word0 = C.NOP + low half of 0x00100093 (stored lower halfword, upper halfword) -> instr at PC 2 not valid until word1 arrives; then instr_o=0x00100093, is_rvc=0.
- Backpressure: instr_ready=0 with HQ_DEPTH=8 -> exactly 4 fetches complete, then icache_ren=0. Raise ready -> ren reasserts once free>=2; no halfword lost or duplicated.
- Redirect to 0x0000_0102 during stall=1 on word address 0x10 -> ren stays high with addr 0x10 until stall=0, that data is dropped, next addr=0x40, and the first instr_pc=0x102.
- Simultaneous redirect + completion + pop -> queue empty next cycle, no instruction from the old stream ever appears.
- Reset asserted while ren=1, stall=1 -> ren=0 and instr_valid=0 immediately; fetch restarts at RESET_PC two cycles after release.
